// File: rtl/compass_pkg.sv
// Shared constants, parser states and heading/delta types for the GY-26 compass link.
package compass_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_DOT = 8'h2E;
    localparam logic [7:0] CHAR_0   = 8'h30;

    localparam int HEADING_MAX  = 3599;
    localparam int HEADING_FULL = 3600;
    localparam int HALF_TURN    = 1800;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_COLLECT,
        ST_DRAIN
    } parse_state_t;

    typedef logic [11:0]        heading_t;
    typedef logic signed [12:0] delta_t;

    // Shortest signed turn from rf to hd, folded into -1799..+1800.
    function automatic delta_t wrap_delta(input heading_t hd, input heading_t rf);
        delta_t raw;
        raw = $signed({1'b0, hd}) - $signed({1'b0, rf});
        if (raw > delta_t'(HALF_TURN))
            wrap_delta = raw - delta_t'(HEADING_FULL);
        else if (raw <= -delta_t'(HALF_TURN))
            wrap_delta = raw + delta_t'(HEADING_FULL);
        else
            wrap_delta = raw;
    endfunction

endpackage

// File: rtl/compass_query_timer.sv
// Periodic angle-query generator: one registered tx strobe per period expiry.
// Latency 1 cycle from pending & !tx_busy; holds at most one query while tx_busy stalls it.
module compass_query_timer
    import compass_pkg::*;
#(
    parameter int          QUERY_PERIOD = 2500000,
    parameter logic [7:0]  QUERY_BYTE   = 8'h31
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       tx_busy,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_en
);

    localparam int QW = $clog2(QUERY_PERIOD);

    logic [QW-1:0] qcnt;
    logic          pending;
    logic          wrap;
    logic          fire;

    assign wrap = (qcnt == QW'(QUERY_PERIOD - 1));
    // The !uart_tx_en term keeps strobes at least one idle cycle apart.
    assign fire = pending && !tx_busy && !uart_tx_en;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            qcnt         <= '0;
            pending      <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= QUERY_BYTE;
        end else begin
            qcnt         <= wrap ? '0 : qcnt + 1'b1;
            uart_tx_en   <= fire;
            uart_tx_data <= QUERY_BYTE;
            if (wrap)
                pending <= 1'b1;
            else if (fire)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/compass_frame_parser.sv
// GY-26 link front end: queries the compass, validates "sDDD.D<CR>" replies, emits heading/delta/stale.
// Latency 1 cycle from the CR strobe to heading_valid; no backpressure, one byte per rxdone accepted.
module compass_frame_parser
    import compass_pkg::*;
#(
    parameter int         QUERY_PERIOD = 2500000,
    parameter int         STALE_LIMIT  = 12500000,
    parameter logic [7:0] QUERY_BYTE   = 8'h31
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        rxdone,
    input  logic [7:0]  rxdata,
    input  logic        tx_busy,
    input  logic        capture_ref,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    output logic [11:0] heading,
    output logic        heading_valid,
    output logic [12:0] delta,
    output logic        frame_err,
    output logic        stale
);

    localparam int SW = $clog2(STALE_LIMIT + 1);

    parse_state_t  state, state_n;
    logic [2:0]    idx, idx_n;
    logic [13:0]   acc, acc_n;
    logic          frame_ok;
    logic          frame_bad;
    logic [7:0]    digit;
    logic          is_digit;
    logic          is_cr;
    logic          class_ok;

    heading_t      ref_hd;
    heading_t      heading_n;
    heading_t      ref_n;
    logic [SW-1:0] stale_cnt;

    compass_query_timer #(
        .QUERY_PERIOD (QUERY_PERIOD),
        .QUERY_BYTE   (QUERY_BYTE)
    ) u_query (
        .clk0         (clk0),
        .rst_n        (rst_n),
        .tx_busy      (tx_busy),
        .uart_tx_data (uart_tx_data),
        .uart_tx_en   (uart_tx_en)
    );

    assign digit    = rxdata - CHAR_0;
    assign is_digit = (rxdata >= CHAR_0) && (rxdata <= 8'h39);
    assign is_cr    = (rxdata == CHAR_CR);
    assign class_ok = (idx == 3'd4) ? (rxdata == CHAR_DOT) : is_digit;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state <= ST_HUNT;
            idx   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        acc_n     = acc;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (rxdone) begin
            unique case (state)
                ST_HUNT: begin
                    if (!is_cr) begin
                        state_n = ST_COLLECT;
                        idx_n   = 3'd1;
                        acc_n   = '0;
                    end
                end
                ST_COLLECT: begin
                    if (idx == 3'd6) begin
                        if (is_cr) begin
                            state_n = ST_HUNT;
                            if (acc <= 14'(HEADING_MAX))
                                frame_ok = 1'b1;
                            else
                                frame_bad = 1'b1;
                        end else begin
                            state_n   = ST_DRAIN;
                            frame_bad = 1'b1;
                        end
                    end else if (class_ok) begin
                        idx_n = idx + 3'd1;
                        if (idx != 3'd4)
                            acc_n = acc * 14'd10 + {6'd0, digit};
                    end else begin
                        // A CR here already terminates the frame, so skip draining.
                        frame_bad = 1'b1;
                        state_n   = is_cr ? ST_HUNT : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (is_cr)
                        state_n = ST_HUNT;
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    assign heading_n = frame_ok ? acc[11:0] : heading;
    assign ref_n     = capture_ref ? heading_n : ref_hd;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            heading       <= '0;
            heading_valid <= 1'b0;
            delta         <= '0;
            frame_err     <= 1'b0;
            ref_hd        <= '0;
            stale         <= 1'b1;
            stale_cnt     <= '0;
        end else begin
            heading       <= heading_n;
            heading_valid <= frame_ok;
            frame_err     <= frame_bad;
            ref_hd        <= ref_n;
            delta         <= wrap_delta(heading_n, ref_n);
            if (frame_ok) begin
                stale_cnt <= '0;
                stale     <= 1'b0;
            end else if (stale_cnt != SW'(STALE_LIMIT)) begin
                stale_cnt <= stale_cnt + 1'b1;
                if (stale_cnt == SW'(STALE_LIMIT - 1))
                    stale <= 1'b1;
            end
        end
    end

endmodule
